// File: rtl/aes_mixcol_seq.sv
// AES MixColumns sequencer.
// One 32-bit MixColumns column unit is shared over the four columns of a
// 128-bit AES state, one column per clock. A bypass path serves the final
// round, where MixColumns is skipped. Valid/ready handshakes on both sides.

// Combinational MixColumns for a single column.
// Byte 0 (S0) is the MSB byte of the column.
module AesMixColumns (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  // Multiply by 2 in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Matrix rows [2 3 1 1], [1 2 3 1], [1 1 2 3], [3 1 1 2]; 3*x = 2*x ^ x.
  always_comb begin
    col_out[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    col_out[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    col_out[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    col_out[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

module aes_mixcol_seq #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic             in_bypass,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [127:0] work;
  logic [1:0]   col_cnt;
  logic [31:0]  mix_in;
  logic [31:0]  mix_out;
  logic         accept;

  // Handshake and status flags all come straight from the FSM state.
  // in_ready is held low while RESET is asserted.
  assign in_ready  = (state == IDLE) && !RESET;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready && !flush;

  // The single shared column unit.
  AesMixColumns u_mix (
    .col_in  (mix_in),
    .col_out (mix_out)
  );

  // Route column col_cnt of the work register into the column unit.
  always_comb begin
    mix_in = work[127:96];
    case (col_cnt)
      2'd0:    mix_in = work[127:96];
      2'd1:    mix_in = work[95:64];
      2'd2:    mix_in = work[63:32];
      default: mix_in = work[31:0];
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides everything and returns to IDLE.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_next = in_bypass ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (col_cnt == 2'd3) begin
            state_next = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: capture the input, write one result column per BUSY cycle,
  // and count completed output handshakes. Flush leaves out_state stale.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      work      <= '0;
      col_cnt   <= 2'd0;
      out_state <= '0;
      blk_cnt   <= '0;
    end else if (flush) begin
      col_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work    <= in_state;
            col_cnt <= 2'd0;
            if (in_bypass) begin
              out_state <= in_state;
            end
          end
        end
        BUSY: begin
          case (col_cnt)
            2'd0:    out_state[127:96] <= mix_out;
            2'd1:    out_state[95:64]  <= mix_out;
            2'd2:    out_state[63:32]  <= mix_out;
            default: out_state[31:0]   <= mix_out;
          endcase
          col_cnt <= (col_cnt == 2'd3) ? 2'd0 : col_cnt + 2'd1;
        end
        DONE: begin
          if (out_ready) begin
            blk_cnt <= blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: col_cnt <= 2'd0;
      endcase
    end
  end

endmodule
